wb_bank_streamer: RTL

//  Command-driven port controller for one single-port bank (A/D/WEN/REN/EN/Q, 1-cycle read latency).

---
 rtl/wb_bank_pkg.sv | 15 +
 rtl/wb_skid_fifo2.sv | 40 ++++
 rtl/wb_bank_streamer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/wb_bank_pkg.sv
// Shared types and default widths for the bank streamer and its FIFO.
package wb_bank_pkg;

  localparam int DEF_ADDR_WIDTH = 13;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_LEN_WIDTH  = 14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN_WR = 2'd1,
    ST_RUN_RD = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/wb_skid_fifo2.sv
// Two-entry FIFO that absorbs the bank read latency and read-stream backpressure.
module wb_skid_fifo2 #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] mem0_q, mem1_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        if (wr_ptr_q) mem1_q <= push_data_i;
        else          mem0_q <= push_data_i;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign head_o  = rd_ptr_q ? mem1_q : mem0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/wb_bank_streamer.sv
// Command-driven port controller moving cmd_len words between one single-port bank
// and valid/ready streams, with a 2-entry FIFO hiding the 1-cycle read latency.
//
// state     | meaning
// ST_IDLE   | waiting for a command, cmd_ready=1
// ST_RUN_WR | write stream -> bank, one word per wr_valid beat
// ST_RUN_RD | bank -> read stream, issue gated by FIFO credit
// ST_DONE   | one-cycle completion pulse
module wb_bank_streamer
  import wb_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bank_A,
  output logic [DATA_WIDTH-1:0] bank_D,
  output logic                  bank_WEN,
  output logic                  bank_REN,
  output logic                  bank_EN,
  input  logic [DATA_WIDTH-1:0] bank_Q
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            fifo_cnt;
  logic [2:0]            occ;
  logic                  accept, beat, pop, issue, last_pop;

  assign accept = cmd_valid && (state_q == ST_IDLE);
  assign beat   = wr_valid && (state_q == ST_RUN_WR);
  assign pop    = rd_valid && rd_ready;
  assign occ    = {1'b0, fifo_cnt} + {2'b00, inflight_q};
  // A slot freed by this cycle's pop can be re-used by this cycle's issue.
  assign issue  = (state_q == ST_RUN_RD) && (rem_q != '0) && (occ < (3'd2 + {2'b00, pop}));
  assign last_pop = (rem_q == '0) && !inflight_q && (fifo_cnt == 2'd1) && pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        if (cmd_len == '0)  state_d = ST_DONE;
        else if (cmd_write) state_d = ST_RUN_WR;
        else                state_d = ST_RUN_RD;
      end
      ST_RUN_WR: if (beat && (rem_q == LEN_WIDTH'(1))) state_d = ST_DONE;
      ST_RUN_RD: if (last_pop) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    wr_ready  = (state_q == ST_RUN_WR);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    bank_EN   = beat || issue;
    bank_WEN  = beat;
    bank_REN  = issue;
    bank_A    = (beat || issue) ? addr_q : '0;
    bank_D    = wr_data;
  end

  always_comb begin
    addr_d     = addr_q;
    rem_d      = rem_q;
    inflight_d = issue;
    if (accept) begin
      addr_d = cmd_base;
      rem_d  = cmd_len;
    end else if (beat || issue) begin
      addr_d = addr_q + 1'b1;
      rem_d  = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
    end
  end

  wb_skid_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_data_i(bank_Q),
    .pop_i      (pop),
    .head_o     (rd_data),
    .count_o    (fifo_cnt)
  );

  assign rd_valid = (fifo_cnt != 2'd0);

endmodule
